// File: rtl/spram_port_arbiter.sv
// Two-requester front end for a single-port synchronous RAM with an optional
// post-reset clear sweep. One access every three cycles; round-robin on ties.
module spram_port_arbiter #(
  parameter int                    address_width  = 8,
  parameter int                    data_width     = 8,
  parameter logic [data_width-1:0] clear_value    = '0,
  parameter bit                    clear_on_reset = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     a_req,
  input  logic                     a_we,
  input  logic [address_width-1:0] a_addr,
  input  logic [data_width-1:0]    a_data,
  output logic                     a_ack,
  output logic [data_width-1:0]    a_q,
  input  logic                     b_req,
  input  logic                     b_we,
  input  logic [address_width-1:0] b_addr,
  input  logic [data_width-1:0]    b_data,
  output logic                     b_ack,
  output logic [data_width-1:0]    b_q,
  output logic                     busy,
  output logic                     ram_enable,
  output logic [address_width-1:0] ram_address,
  output logic [data_width-1:0]    ram_data,
  output logic                     ram_wren,
  input  logic [data_width-1:0]    ram_q
);

  typedef enum logic [1:0] {
    st_clear,
    st_idle,
    st_wait,
    st_ack
  } state_t;

  localparam logic [address_width-1:0] last_address = '1;

  state_t                     state;
  logic [address_width-1:0]   counter;
  logic                       owner_b;
  logic                       last_grant_b;
  logic                       grant_b;

  // B wins when it asks alone, or when both ask and A had the previous grant.
  assign grant_b = b_req & (~a_req | ~last_grant_b);

  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    ram_enable  = 1'b0;
    ram_wren    = 1'b0;
    ram_address = '0;
    ram_data    = '0;
    if (reset_n) begin
      case (state)
        st_clear: begin
          ram_enable  = 1'b1;
          ram_wren    = 1'b1;
          ram_address = counter;
          ram_data    = clear_value;
        end
        st_idle: begin
          if (a_req || b_req) begin
            ram_enable  = 1'b1;
            ram_wren    = grant_b ? b_we   : a_we;
            ram_address = grant_b ? b_addr : a_addr;
            ram_data    = grant_b ? b_data : a_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= clear_on_reset ? st_clear : st_idle;
      counter      <= '0;
      owner_b      <= 1'b0;
      last_grant_b <= 1'b1;
      busy         <= clear_on_reset;
      a_ack        <= 1'b0;
      b_ack        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state)
        st_clear: begin
          counter <= counter + 1'b1;
          if (counter == last_address) begin
            state <= st_idle;
            busy  <= 1'b0;
          end
        end
        st_idle: begin
          if (a_req || b_req) begin
            owner_b      <= grant_b;
            last_grant_b <= grant_b;
            state        <= st_wait;
          end
        end
        st_wait: begin
          // RAM output is valid one edge after the issue edge.
          if (owner_b) begin
            b_q   <= ram_q;
            b_ack <= 1'b1;
          end else begin
            a_q   <= ram_q;
            a_ack <= 1'b1;
          end
          state <= st_ack;
        end
        default: state <= st_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_spram_port_arbiter.sv
// Bench for spram_port_arbiter: behavioural RAM, transaction-timeline reference
// model checked every cycle, directed scenarios plus randomized requesters.
module tb_spram_port_arbiter;

  localparam int          aw    = 4;
  localparam int          dw    = 8;
  localparam int          depth = 1 << aw;
  localparam logic [7:0]  clr   = 8'hA5;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [aw-1:0] a_addr = '0, b_addr = '0;
  logic [dw-1:0] a_data = '0, b_data = '0;
  logic          a_ack, b_ack, busy, ram_enable, ram_wren;
  logic [dw-1:0] a_q, b_q, ram_data, ram_q;
  logic [aw-1:0] ram_address;

  logic [dw-1:0] mem [depth];

  int checks = 0;
  int errors = 0;

  // Reference model: sweep position plus cycles elapsed since the last issue.
  bit            m_sweep;
  int            m_saddr;
  int            m_t;
  bit            m_own_b;
  bit            m_last_b;
  logic [dw-1:0] m_exp, m_aq, m_bq;
  logic [dw-1:0] refmem [depth];

  spram_port_arbiter #(
    .address_width (aw),
    .data_width    (dw),
    .clear_value   (clr),
    .clear_on_reset(1'b1)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .a_req      (a_req),
    .a_we       (a_we),
    .a_addr     (a_addr),
    .a_data     (a_data),
    .a_ack      (a_ack),
    .a_q        (a_q),
    .b_req      (b_req),
    .b_we       (b_we),
    .b_addr     (b_addr),
    .b_data     (b_data),
    .b_ack      (b_ack),
    .b_q        (b_q),
    .busy       (busy),
    .ram_enable (ram_enable),
    .ram_address(ram_address),
    .ram_data   (ram_data),
    .ram_wren   (ram_wren),
    .ram_q      (ram_q)
  );

  always #5 clock = ~clock;

  // Single-port RAM with registered, read-before-write output.
  always_ff @(posedge clock) begin
    if (ram_enable) begin
      ram_q <= mem[ram_address];
      if (ram_wren) mem[ram_address] <= ram_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_sweep  = 1'b1;
    m_saddr  = 0;
    m_t      = 0;
    m_own_b  = 1'b0;
    m_last_b = 1'b1;
    m_aq     = '0;
    m_bq     = '0;
  endfunction

  // Called at a falling edge once inputs are set: checks the RAM pins, advances
  // the model over the next rising edge, then checks registered outputs.
  task automatic tick();
    bit g;
    #1;
    if (!reset_n) begin
      check("ram_enable_reset", ram_enable, 0);
      check("ram_wren_reset", ram_wren, 0);
      model_reset();
    end else if (m_sweep) begin
      check("sweep_enable", ram_enable, 1);
      check("sweep_wren", ram_wren, 1);
      check("sweep_addr", ram_address, m_saddr);
      check("sweep_data", ram_data, clr);
      refmem[m_saddr] = clr;
      m_saddr++;
      if (m_saddr == depth) m_sweep = 1'b0;
    end else if (m_t == 2) begin
      check("ack_cycle_enable", ram_enable, 0);
      m_t = 0;
    end else if (m_t == 1) begin
      check("wait_cycle_enable", ram_enable, 0);
      m_t = 2;
      if (m_own_b) m_bq = m_exp;
      else         m_aq = m_exp;
    end else if (a_req || b_req) begin
      g = b_req && (!a_req || !m_last_b);
      check("issue_enable", ram_enable, 1);
      check("issue_wren", ram_wren, g ? b_we : a_we);
      check("issue_addr", ram_address, g ? b_addr : a_addr);
      check("issue_data", ram_data, g ? b_data : a_data);
      if (g) begin
        m_exp = refmem[b_addr];
        if (b_we) refmem[b_addr] = b_data;
      end else begin
        m_exp = refmem[a_addr];
        if (a_we) refmem[a_addr] = a_data;
      end
      m_own_b  = g;
      m_last_b = g;
      m_t      = 1;
    end else begin
      check("idle_enable", ram_enable, 0);
    end
    @(negedge clock);
    check("busy", busy, m_sweep);
    check("a_ack", a_ack, (m_t == 2) && !m_own_b);
    check("b_ack", b_ack, (m_t == 2) && m_own_b);
    check("a_q", a_q, m_aq);
    check("b_q", b_q, m_bq);
  endtask

  task automatic do_access(input bit port_b, input bit we, input logic [aw-1:0] addr,
                           input logic [dw-1:0] data, output logic [dw-1:0] q, output int lat);
    bit done = 1'b0;
    lat = 0;
    q   = '0;
    if (port_b) begin b_req = 1'b1; b_we = we; b_addr = addr; b_data = data; end
    else        begin a_req = 1'b1; a_we = we; a_addr = addr; a_data = data; end
    for (int i = 0; i < 60 && !done; i++) begin
      tick();
      lat++;
      if (port_b ? b_ack : a_ack) begin
        done = 1'b1;
        q    = port_b ? b_q : a_q;
      end
    end
    if (!done) check("access_timeout", 0, 1);
    a_req = 1'b0;
    b_req = 1'b0;
    tick();
  endtask

  task automatic sweep_until_idle(input string name);
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check(name, n, depth);
    for (int i = 0; i < depth; i++) check("mem_cleared", mem[i], clr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [dw-1:0] q;
    int            lat;
    logic [11:0]   a_pat, b_pat;
    int            n;
    bit            done;

    model_reset();
    tick();
    check("reset_busy", busy, 1);
    check("reset_a_q", a_q, 0);
    tick();

    // Post-reset sweep: 16 cycles of A5 writes.
    reset_n = 1'b1;
    sweep_until_idle("sweep_len");

    // A reads a freshly cleared word.
    do_access(1'b0, 1'b0, 4'd3, 8'h00, q, lat);
    check("a_read3_q", q, 8'hA5);
    check("a_read3_lat", lat, 2);

    // A writes 3C to 7 (old data returned), B reads it back.
    do_access(1'b0, 1'b1, 4'd7, 8'h3C, q, lat);
    check("a_write7_old", q, 8'hA5);
    do_access(1'b1, 1'b0, 4'd7, 8'h00, q, lat);
    check("b_read7_q", q, 8'h3C);
    check("b_read7_lat", lat, 2);

    // Both hold requests: grants alternate A,B,A,B, acks three cycles apart.
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'd7;
    for (int i = 0; i < 12; i++) begin
      tick();
      a_pat[i] = a_ack;
      b_pat[i] = b_ack;
    end
    check("alternate_a", a_pat, 12'h082);
    check("alternate_b", b_pat, 12'h410);
    check("alternate_b_q", b_q, 8'h3C);
    a_req = 1'b0;
    b_req = 1'b0;
    tick();

    // B requests during the sweep: served only once it completes.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'd2;
    n = 0;
    done = 1'b0;
    while (!done && n < 60) begin
      tick();
      n++;
      if (b_ack) done = 1'b1;
    end
    check("b_during_sweep_lat", n, depth + 2);
    check("b_during_sweep_q", b_q, 8'hA5);
    b_req = 1'b0;
    tick();

    // Reset in mid-sweep: sweep restarts from address 0.
    do_access(1'b0, 1'b1, 4'd12, 8'h3C, q, lat);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n = 0;
    while (m_saddr != 9 && n < 40) begin
      tick();
      n++;
    end
    check("reach_addr9", n, 9);
    reset_n = 1'b0;
    tick();
    check("mid_reset_busy", busy, 1);
    check("mid_reset_mem12", mem[12], 8'h3C);
    reset_n = 1'b1;
    sweep_until_idle("resweep_len");

    // Randomized requesters holding each request until acknowledged.
    for (int i = 0; i < 600; i++) begin
      if (!a_req && $urandom_range(0, 2) == 0) begin
        a_req  = 1'b1;
        a_we   = 1'($urandom_range(0, 1));
        a_addr = aw'($urandom);
        a_data = dw'($urandom);
      end
      if (!b_req && $urandom_range(0, 2) == 0) begin
        b_req  = 1'b1;
        b_we   = 1'($urandom_range(0, 1));
        b_addr = aw'($urandom);
        b_data = dw'($urandom);
      end
      tick();
      if (a_ack) a_req = 1'b0;
      if (b_ack) b_req = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
